// File: rtl/iter_hasher.sv
// iter_hasher: sequential two-lane byte hasher.
// Accepts one message (up to MAX_BYTES bytes plus a byte count) per input
// handshake. It folds one byte per clock into two alternating lanes, then
// presents the mixed hash on an output valid/ready handshake.
// Ports:
//   clk, rst          - rising-edge clock, async active-high reset
//   in_valid/in_ready - message handshake (data, data_len)
//   data              - message bytes, byte i = data[8i+7:8i]
//   data_len          - requested byte count (clipped to MAX_BYTES)
//   out_valid/out_ready - result handshake (hash, len_err)
//   hash              - final mixed hash
//   len_err           - data_len exceeded MAX_BYTES, message truncated
//   busy              - high while hashing or holding a result
module iter_hasher #(
  parameter int unsigned STATE_W   = 32,
  parameter int unsigned MAX_BYTES = 8,
  parameter int unsigned LEN_W     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [8*MAX_BYTES-1:0]   data,
  input  logic [LEN_W-1:0]         data_len,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [STATE_W-1:0]       hash,
  output logic                     len_err,
  output logic                     busy
);

  localparam int unsigned DATA_W = 8 * MAX_BYTES;
  localparam logic [STATE_W-1:0] INIT_A = {(STATE_W/2){2'b01}};
  localparam logic [STATE_W-1:0] INIT_B = {(STATE_W/2){2'b10}};
  localparam logic [LEN_W-1:0]   MAX_LEN = LEN_W'(MAX_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [DATA_W-1:0]    r_data, w_data_nxt;
  logic [LEN_W-1:0]     r_len, w_len_nxt;
  logic [LEN_W-1:0]     r_idx, w_idx_nxt;
  logic                 r_len_err_q, w_len_err_q_nxt;
  logic [STATE_W-1:0]   r_a, w_a_nxt;
  logic [STATE_W-1:0]   r_b, w_b_nxt;
  logic [STATE_W-1:0]   r_hash, w_hash_nxt;
  logic                 r_len_err, w_len_err_nxt;
  logic                 r_in_ready, w_in_ready_nxt;
  logic                 r_out_valid, w_out_valid_nxt;
  logic                 r_busy, w_busy_nxt;

  logic [7:0]           w_byte;
  logic [STATE_W-1:0]   w_byte_ext;
  int unsigned          w_rot_run;
  int unsigned          w_rot_fin;

  // Pure bit rotation; r is always < STATE_W, and r == 0 is the identity
  // because the right shift by STATE_W yields zero.
  function automatic logic [STATE_W-1:0] rotl(input logic [STATE_W-1:0] x,
                                               input int unsigned r);
    rotl = (x << r) | (x >> (STATE_W - r));
  endfunction

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign hash      = r_hash;
  assign len_err   = r_len_err;
  assign busy      = r_busy;

  // Current byte and rotation amounts. A shift is used instead of an indexed
  // part-select so the final idx == eff_len cycle never selects out of range.
  assign w_byte     = 8'(r_data >> {r_idx, 3'b000});
  assign w_byte_ext = STATE_W'(w_byte);
  assign w_rot_run  = (32'(r_idx) + 32'd1) % STATE_W;
  assign w_rot_fin  = 32'(r_len) % STATE_W;

  // Next-state and next-register values.
  always_comb begin
    w_state_nxt     = r_state;
    w_data_nxt      = r_data;
    w_len_nxt       = r_len;
    w_idx_nxt       = r_idx;
    w_len_err_q_nxt = r_len_err_q;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_hash_nxt      = r_hash;
    w_len_err_nxt   = r_len_err;
    w_in_ready_nxt  = r_in_ready;
    w_out_valid_nxt = r_out_valid;
    w_busy_nxt      = r_busy;

    case (r_state)
      IDLE: begin
        if (in_valid && r_in_ready) begin
          w_data_nxt      = data;
          w_len_nxt       = (data_len > MAX_LEN) ? MAX_LEN : data_len;
          w_len_err_q_nxt = (data_len > MAX_LEN);
          w_a_nxt         = INIT_A;
          w_b_nxt         = INIT_B;
          w_idx_nxt       = '0;
          w_state_nxt     = RUN;
          w_in_ready_nxt  = 1'b0;
          w_busy_nxt      = 1'b1;
        end
      end
      RUN: begin
        if (r_idx < r_len) begin
          // Even byte indices fold into lane A, odd into lane B.
          if (!r_idx[0]) begin
            w_a_nxt = rotl(r_a ^ w_byte_ext, w_rot_run);
          end else begin
            w_b_nxt = rotl(r_b ^ w_byte_ext, w_rot_run);
          end
          w_idx_nxt = LEN_W'(r_idx + 1'b1);
        end else begin
          w_hash_nxt      = rotl(r_a ^ r_b, w_rot_fin);
          w_len_err_nxt   = r_len_err_q;
          w_state_nxt     = DONE;
          w_out_valid_nxt = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt     = IDLE;
          w_out_valid_nxt = 1'b0;
          w_in_ready_nxt  = 1'b1;
          w_busy_nxt      = 1'b0;
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_out_valid_nxt = 1'b0;
        w_in_ready_nxt  = 1'b1;
        w_busy_nxt      = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_data      <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_len_err_q <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_hash      <= '0;
      r_len_err   <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_data      <= w_data_nxt;
      r_len       <= w_len_nxt;
      r_idx       <= w_idx_nxt;
      r_len_err_q <= w_len_err_q_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_hash      <= w_hash_nxt;
      r_len_err   <= w_len_err_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

endmodule

// File: tb/tb_iter_hasher.sv
// Directed self-checking bench for iter_hasher (default parameters).
module tb_iter_hasher;

  localparam int unsigned STATE_W   = 32;
  localparam int unsigned MAX_BYTES = 8;
  localparam int unsigned LEN_W     = 4;
  localparam int          MAX_WAIT  = 50;

  logic                   clk;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [8*MAX_BYTES-1:0] data;
  logic [LEN_W-1:0]       data_len;
  logic                   out_valid;
  logic                   out_ready;
  logic [STATE_W-1:0]     hash;
  logic                   len_err;
  logic                   busy;

  int errors;
  int checks;

  iter_hasher #(
    .STATE_W  (STATE_W),
    .MAX_BYTES(MAX_BYTES),
    .LEN_W    (LEN_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data     (data),
    .data_len (data_len),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .hash     (hash),
    .len_err  (len_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one message, then scramble the inputs after the accepting edge
  // and count edges until out_valid (bounded).
  task automatic send_msg(input logic [63:0] d, input logic [3:0] l, output int lat);
    @(negedge clk);
    data     = d;
    data_len = l;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data     = ~d;
    data_len = 4'hF;
    lat = 0;
    while (!out_valid && lat < MAX_WAIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (hash !== 32'h0) begin errors++; $display("FAIL reset_hash got=%h exp=00000000", hash); end
    checks++;
    if (len_err !== 1'b0) begin errors++; $display("FAIL reset_len_err got=%b exp=0", len_err); end
  endtask

  task automatic test_len0();
    int lat;
    send_msg(64'h0, 4'd0, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL len0_latency got=%0d exp=1", lat); end
    checks++;
    if (hash !== 32'hFFFF_FFFF) begin errors++; $display("FAIL len0_hash got=%h exp=ffffffff", hash); end
    checks++;
    if (len_err !== 1'b0) begin errors++; $display("FAIL len0_len_err got=%b exp=0", len_err); end
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL len0_done_flags busy=%b in_ready=%b exp busy=1 in_ready=0", busy, in_ready);
    end
    consume();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL len0_release out_valid=%b in_ready=%b busy=%b exp 0/1/0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_len1();
    int lat;
    send_msg(64'h01, 4'd1, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL len1_latency got=%0d exp=2", lat); end
    checks++;
    if (hash !== 32'h0000_0004) begin errors++; $display("FAIL len1_hash got=%h exp=00000004", hash); end
    consume();
  endtask

  task automatic test_upper_ignored();
    int lat;
    send_msg(64'hFFFF_FFFF_FFFF_0000, 4'd2, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL len2_latency got=%0d exp=3", lat); end
    checks++;
    if (hash !== 32'h0) begin errors++; $display("FAIL len2_upper_hash got=%h exp=00000000", hash); end
    consume();
    send_msg(64'hFFFF_FFFF_FFFF_FF01, 4'd1, lat);
    checks++;
    if (hash !== 32'h0000_0004) begin errors++; $display("FAIL len1_upper_hash got=%h exp=00000004", hash); end
    consume();
  endtask

  // D: byte0=0x01, byte1=0x02, byte7=0x80 -> hash 0xDE7FFFFF over 8 bytes.
  task automatic test_len_clip();
    int lat;
    send_msg(64'h8000_0000_0000_0201, 4'd9, lat);
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL len9_latency got=%0d exp=9", lat); end
    checks++;
    if (hash !== 32'hDE7F_FFFF) begin errors++; $display("FAIL len9_hash got=%h exp=de7fffff", hash); end
    checks++;
    if (len_err !== 1'b1) begin errors++; $display("FAIL len9_len_err got=%b exp=1", len_err); end
    consume();
    send_msg(64'h8000_0000_0000_0201, 4'd8, lat);
    checks++;
    if (hash !== 32'hDE7F_FFFF) begin errors++; $display("FAIL len8_hash got=%h exp=de7fffff", hash); end
    checks++;
    if (len_err !== 1'b0) begin errors++; $display("FAIL len8_len_err got=%b exp=0", len_err); end
    consume();
    send_msg(64'h8000_0000_0000_0201, 4'd15, lat);
    checks++;
    if (hash !== 32'hDE7F_FFFF || len_err !== 1'b1) begin
      errors++; $display("FAIL len15 hash=%h len_err=%b exp=de7fffff/1", hash, len_err);
    end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    send_msg(64'h01, 4'd1, lat);
    @(negedge clk);
    data      = 64'hFFFF_FFFF_FFFF_0000;
    data_len  = 4'd2;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || hash !== 32'h4) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d out_valid=%b in_ready=%b hash=%h exp 1/0/00000004",
                 i, out_valid, in_ready, hash);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
    end
    @(negedge clk);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_accept busy=%b in_ready=%b exp 1/0", busy, in_ready);
    end
    lat = 0;
    while (!out_valid && lat < MAX_WAIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat !== 3 || hash !== 32'h0) begin
      errors++; $display("FAIL bp_next lat=%0d hash=%h exp 3/00000000", lat, hash);
    end
    consume();
  endtask

  task automatic test_reset_midrun();
    int lat;
    send_msg(64'h01, 4'd1, lat);
    consume();
    @(negedge clk);
    data     = 64'h1122_3344_5566_7788;
    data_len = 4'd8;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || hash !== 32'h0) begin
      errors++;
      $display("FAIL midrun_reset out_valid=%b in_ready=%b busy=%b hash=%h exp 0/1/0/00000000",
               out_valid, in_ready, busy, hash);
    end
    @(negedge clk);
    rst = 1'b0;
    send_msg(64'h01, 4'd1, lat);
    checks++;
    if (lat !== 2 || hash !== 32'h4 || len_err !== 1'b0) begin
      errors++;
      $display("FAIL post_reset lat=%0d hash=%h len_err=%b exp 2/00000004/0", lat, hash, len_err);
    end
    consume();
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data      = '0;
    data_len  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    test_reset();
    test_len0();
    test_len1();
    test_upper_ignored();
    test_len_clip();
    test_backpressure();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
